// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the OBI manager arbiter.
// Optional build macro used by the arbiter: OBI_MGR_ARBITER_FIXED_PRIO_EN.
package obi_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 2;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_MAX_OUTST  = 4;
    localparam int unsigned BE_WIDTH       = 4;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // (a + b) mod n, valid while both operands are below n.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding downstream transactions.
// Push is ignored when full and pop is ignored when empty.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_MAX_OUTST,
    parameter int unsigned ID_W  = 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [ID_W-1:0]  push_id,
    input  logic             pop,
    output logic [ID_W-1:0]  head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = idx_width(DEPTH);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/obi_mgr_arbiter.sv
// Shares one OBI manager port between NUM_REQ requesters and routes in-order responses back.
// Define OBI_MGR_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module obi_mgr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned MAX_OUTST  = DEF_MAX_OUTST
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_REQ*BE_WIDTH-1:0]   be_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          mgr_req_o,
    output logic                          mgr_we_o,
    output logic [ADDR_WIDTH-1:0]         mgr_addr_o,
    output logic [DATA_WIDTH-1:0]         mgr_wdata_o,
    output logic [BE_WIDTH-1:0]           mgr_be_o,
    input  logic                          mgr_gnt_i,
    input  logic                          mgr_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         mgr_rdata_i,
    output logic                          busy_o
);

    localparam int unsigned ID_W  = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

    arb_state_e           state;
    logic [ID_W-1:0]      hold_sel;
    logic [ID_W-1:0]      pick_sel;
    logic [ID_W-1:0]      sel;
    logic [NUM_REQ-1:0]   rot_req;
    logic                 found;
    logic                 req_c;
    logic                 grant_c;
    logic                 pop_c;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ID_W-1:0]      fifo_head;
    logic [CNT_W-1:0]     fifo_count;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [BE_WIDTH-1:0]   be_arr    [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign be_arr[g]    = be_i[g*BE_WIDTH +: BE_WIDTH];
    end

`ifndef OBI_MGR_ARBITER_FIXED_PRIO_EN
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      next_ptr;
    logic [2*NUM_REQ-1:0] req_dbl;

    assign req_dbl  = {req_i, req_i} >> ptr;
    assign rot_req  = req_dbl[NUM_REQ-1:0];
    assign next_ptr = ID_W'(wrap_add(32'(sel), 1, NUM_REQ));
`else
    assign rot_req  = req_i;
`endif

    // First requester at or after the pointer (or lowest index in fixed-priority builds).
    always_comb begin
        pick_sel = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && rot_req[k]) begin
                found    = 1'b1;
`ifndef OBI_MGR_ARBITER_FIXED_PRIO_EN
                pick_sel = ID_W'(wrap_add(32'(ptr), k, NUM_REQ));
`else
                pick_sel = ID_W'(k);
`endif
            end
        end
    end

    // Downstream request and upstream grant/response steering; all quiet while in reset.
    always_comb begin
        sel     = (state == HOLD) ? hold_sel : pick_sel;
        req_c   = (state == HOLD) ? 1'b1 : (found && !fifo_full);
        if (rst_i) req_c = 1'b0;
        grant_c = req_c && mgr_gnt_i;
        pop_c   = mgr_rvalid_i && !fifo_empty && !rst_i;

        mgr_req_o   = req_c;
        mgr_we_o    = req_c && we_i[sel];
        mgr_addr_o  = req_c ? addr_arr[sel]  : '0;
        mgr_wdata_o = req_c ? wdata_arr[sel] : '0;
        mgr_be_o    = req_c ? be_arr[sel]    : '0;

        gnt_o    = grant_c ? (NUM_REQ'(1) << sel) : '0;
        rvalid_o = pop_c ? (NUM_REQ'(1) << fifo_head) : '0;
        rdata_o  = rst_i ? '0 : mgr_rdata_i;
        busy_o   = (fifo_count != '0);
    end

    // ARB forwards immediately; an ungranted selection is frozen in HOLD until granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ARB;
            hold_sel <= '0;
`ifndef OBI_MGR_ARBITER_FIXED_PRIO_EN
            ptr      <= '0;
`endif
        end else begin
            case (state)
                ARB: begin
                    if (req_c) begin
                        if (mgr_gnt_i) begin
`ifndef OBI_MGR_ARBITER_FIXED_PRIO_EN
                            ptr <= next_ptr;
`endif
                        end else begin
                            hold_sel <= sel;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (mgr_gnt_i) begin
`ifndef OBI_MGR_ARBITER_FIXED_PRIO_EN
                        ptr <= next_ptr;
`endif
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .ID_W  (ID_W)
    ) u_id_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (grant_c),
        .push_id (sel),
        .pop     (pop_c),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_obi_mgr_arbiter.sv
// Self-checking bench for obi_mgr_arbiter: directed table, hand sequences, randomized traffic vs a queue model.
module tb_obi_mgr_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 4;
    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [NR-1:0]   req_i = '0;
    logic [NR-1:0]   we_i = '0;
    logic [NR*AW-1:0] addr_i = '0;
    logic [NR*DW-1:0] wdata_i = '0;
    logic [NR*4-1:0] be_i = '0;
    logic [NR-1:0]   gnt_o;
    logic [NR-1:0]   rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            mgr_req_o;
    logic            mgr_we_o;
    logic [AW-1:0]   mgr_addr_o;
    logic [DW-1:0]   mgr_wdata_o;
    logic [3:0]      mgr_be_o;
    logic            mgr_gnt_i = 1'b0;
    logic            mgr_rvalid_i = 1'b0;
    logic [DW-1:0]   mgr_rdata_i = '0;
    logic            busy_o;

    always #5 clk = ~clk;

    obi_mgr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTST(MO)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mgr_req_o(mgr_req_o), .mgr_we_o(mgr_we_o), .mgr_addr_o(mgr_addr_o),
        .mgr_wdata_o(mgr_wdata_o), .mgr_be_o(mgr_be_o), .mgr_gnt_i(mgr_gnt_i),
        .mgr_rvalid_i(mgr_rvalid_i), .mgr_rdata_i(mgr_rdata_i), .busy_o(busy_o)
    );

    // Requester payloads presented on the upstream ports.
    logic [31:0] pa [NR];
    logic [31:0] pwd [NR];
    logic        pwe [NR];
    logic [3:0]  pbe [NR];

    // Reference model: owner queue, rotation pointer, held selection.
    int mq[$];
    int mptr;
    bit mheld;
    int mhidx;

    logic [NR-1:0] e_gnt, e_rv;
    logic          e_req, e_busy;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic [1:0]  req;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic [1:0]  x_gnt;
        logic [1:0]  x_rv;
        logic        x_req;
        logic [31:0] x_addr;
        logic        x_busy;
    } vec_t;

    vec_t tbl [17];
    bit   pend [NR];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        mptr  = 0;
        mheld = 1'b0;
        mhidx = 0;
    endtask

    // One bus cycle: drive, check every output against the model, advance the model.
    task automatic step(input logic [NR-1:0] req, input logic g, input logic rv, input logic [31:0] rd);
        int  sel;
        bit  any;
        @(negedge clk);
        req_i = req; mgr_gnt_i = g; mgr_rvalid_i = rv; mgr_rdata_i = rd;
        for (int k = 0; k < NR; k++) begin
            addr_i[k*AW +: AW]  = pa[k];
            wdata_i[k*DW +: DW] = pwd[k];
            we_i[k]             = pwe[k];
            be_i[k*4 +: 4]      = pbe[k];
        end
        #1;
        e_req = 1'b0;
        sel   = 0;
        if (mheld) begin
            e_req = 1'b1;
            sel   = mhidx;
        end else if (mq.size() < MO && req != '0) begin
            e_req = 1'b1;
`ifdef OBI_MGR_ARBITER_FIXED_PRIO_EN
            for (int i = NR - 1; i >= 0; i--) if (req[i]) sel = i;
`else
            any = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (!any && req[(mptr + i) % NR]) begin
                    sel = (mptr + i) % NR;
                    any = 1'b1;
                end
            end
`endif
        end
        e_gnt  = (e_req && g) ? (NR'(1) << sel) : '0;
        e_rv   = (rv && mq.size() != 0) ? (NR'(1) << mq[0]) : '0;
        e_busy = (mq.size() != 0);

        chk("gnt",       32'(gnt_o),     32'(e_gnt));
        chk("rvalid",    32'(rvalid_o),  32'(e_rv));
        chk("rdata",     rdata_o,        rd);
        chk("mgr_req",   32'(mgr_req_o), 32'(e_req));
        chk("mgr_addr",  mgr_addr_o,     e_req ? pa[sel] : 32'h0);
        chk("mgr_we",    32'(mgr_we_o),  32'(e_req ? pwe[sel] : 1'b0));
        chk("mgr_wdata", mgr_wdata_o,    e_req ? pwd[sel] : 32'h0);
        chk("mgr_be",    32'(mgr_be_o),  32'(e_req ? pbe[sel] : 4'h0));
        chk("busy",      32'(busy_o),    32'(e_busy));

        if (rv && mq.size() != 0) void'(mq.pop_front());
        if (e_req && g) begin
            mq.push_back(sel);
            mptr  = (sel + 1) % NR;
            mheld = 1'b0;
        end else if (e_req) begin
            mheld = 1'b1;
            mhidx = sel;
        end
    endtask

    // Reset with live-looking inputs; every output must read zero while rst_i is high.
    task automatic do_reset(input logic [NR-1:0] req);
        @(negedge clk);
        rst_i = 1'b1; req_i = req; mgr_gnt_i = 1'b1; mgr_rvalid_i = 1'b1; mgr_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("rst_gnt",     32'(gnt_o),     32'h0);
        chk("rst_rvalid",  32'(rvalid_o),  32'h0);
        chk("rst_rdata",   rdata_o,        32'h0);
        chk("rst_mgr_req", 32'(mgr_req_o), 32'h0);
        chk("rst_addr",    mgr_addr_o,     32'h0);
        chk("rst_busy",    32'(busy_o),    32'h0);
        @(negedge clk);
        rst_i = 1'b0; req_i = '0; mgr_gnt_i = 1'b0; mgr_rvalid_i = 1'b0; mgr_rdata_i = '0;
        model_clear();
    endtask

    initial begin
        for (int k = 0; k < NR; k++) begin
            pwd[k] = 32'hC0DE_0000 + 32'(k);
            pwe[k] = 1'b0;
            pbe[k] = 4'hF;
        end
        pa[0] = A0; pa[1] = A1;

        //               req    g     rv    rdata          gnt    rv     req   addr   busy
        tbl[0]  = '{2'b11, 1'b1, 1'b0, 32'h0,  2'b01, 2'b00, 1'b1, A0,    1'b0};
        tbl[1]  = '{2'b11, 1'b1, 1'b1, 32'h11, 2'b10, 2'b01, 1'b1, A1,    1'b1};
        tbl[2]  = '{2'b11, 1'b1, 1'b1, 32'h12, 2'b01, 2'b10, 1'b1, A0,    1'b1};
        tbl[3]  = '{2'b11, 1'b1, 1'b1, 32'h13, 2'b10, 2'b01, 1'b1, A1,    1'b1};
        tbl[4]  = '{2'b00, 1'b0, 1'b1, 32'h14, 2'b00, 2'b10, 1'b0, 32'h0, 1'b1};
        tbl[5]  = '{2'b00, 1'b0, 1'b1, 32'h15, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0};
        tbl[6]  = '{2'b01, 1'b1, 1'b0, 32'h0,  2'b01, 2'b00, 1'b1, A0,    1'b0};
        tbl[7]  = '{2'b10, 1'b1, 1'b0, 32'h0,  2'b10, 2'b00, 1'b1, A1,    1'b1};
        tbl[8]  = '{2'b10, 1'b1, 1'b0, 32'h0,  2'b10, 2'b00, 1'b1, A1,    1'b1};
        tbl[9]  = '{2'b01, 1'b1, 1'b0, 32'h0,  2'b01, 2'b00, 1'b1, A0,    1'b1};
        tbl[10] = '{2'b11, 1'b1, 1'b0, 32'h0,  2'b00, 2'b00, 1'b0, 32'h0, 1'b1};
        tbl[11] = '{2'b11, 1'b1, 1'b1, 32'hA,  2'b00, 2'b01, 1'b0, 32'h0, 1'b1};
        tbl[12] = '{2'b11, 1'b1, 1'b1, 32'hB,  2'b10, 2'b10, 1'b1, A1,    1'b1};
        tbl[13] = '{2'b00, 1'b0, 1'b1, 32'hC,  2'b00, 2'b10, 1'b0, 32'h0, 1'b1};
        tbl[14] = '{2'b00, 1'b0, 1'b1, 32'hD,  2'b00, 2'b01, 1'b0, 32'h0, 1'b1};
        tbl[15] = '{2'b00, 1'b0, 1'b1, 32'hE,  2'b00, 2'b10, 1'b0, 32'h0, 1'b1};
        tbl[16] = '{2'b00, 1'b0, 1'b0, 32'h0,  2'b00, 2'b00, 1'b0, 32'h0, 1'b0};

        do_reset(2'b11);

`ifndef OBI_MGR_ARBITER_FIXED_PRIO_EN
        // Round-robin, outstanding limit and response routing.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].req, tbl[i].g, tbl[i].rv, tbl[i].rd);
            chk($sformatf("tbl%0d_gnt", i),     32'(gnt_o),     32'(tbl[i].x_gnt));
            chk($sformatf("tbl%0d_rvalid", i),  32'(rvalid_o),  32'(tbl[i].x_rv));
            chk($sformatf("tbl%0d_mgr_req", i), 32'(mgr_req_o), 32'(tbl[i].x_req));
            chk($sformatf("tbl%0d_addr", i),    mgr_addr_o,     tbl[i].x_addr);
            chk($sformatf("tbl%0d_busy", i),    32'(busy_o),    32'(tbl[i].x_busy));
            if (tbl[i].x_rv != 2'b00) chk($sformatf("tbl%0d_rdata", i), rdata_o, tbl[i].rd);
        end
`else
        // Fixed priority: requester 0 always wins, requester 1 starves.
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 1'b1, (i > 0), 32'h0);
            chk($sformatf("fp%0d_gnt", i), 32'(gnt_o), 32'h1);
        end
        do_reset(2'b00);
`endif

        // Stall/hold: requester 1 at 0x100 stalls 3 cycles while requester 0 joins.
        do_reset(2'b00);
        pa[1] = 32'h0000_0100; pa[0] = 32'h0000_0200;
        step(2'b10, 1'b0, 1'b0, 32'h0);
        chk("hold1_addr", mgr_addr_o, 32'h100); chk("hold1_gnt", 32'(gnt_o), 32'h0);
        step(2'b11, 1'b0, 1'b0, 32'h0);
        chk("hold2_addr", mgr_addr_o, 32'h100); chk("hold2_gnt", 32'(gnt_o), 32'h0);
        step(2'b11, 1'b0, 1'b0, 32'h0);
        chk("hold3_addr", mgr_addr_o, 32'h100);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        chk("hold4_gnt", 32'(gnt_o), 32'h2); chk("hold4_addr", mgr_addr_o, 32'h100);
        step(2'b01, 1'b1, 1'b0, 32'h0);
        chk("hold5_gnt", 32'(gnt_o), 32'h1); chk("hold5_addr", mgr_addr_o, 32'h200);
        chk("hold5_busy", 32'(busy_o), 32'h1);

        // Reset with two outstanding: late response dropped, pointer back to 0.
        do_reset(2'b11);
        step(2'b00, 1'b0, 1'b1, 32'h55);
        chk("postrst_rvalid", 32'(rvalid_o), 32'h0); chk("postrst_busy", 32'(busy_o), 32'h0);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        chk("postrst_gnt", 32'(gnt_o), 32'h1);
        step(2'b00, 1'b0, 1'b1, 32'h66);
        chk("postrst_route", 32'(rvalid_o), 32'h1);

        // Randomized OBI-compliant traffic against the model.
        do_reset(2'b00);
        for (int k = 0; k < NR; k++) pend[k] = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            logic [NR-1:0] rq;
            for (int k = 0; k < NR; k++) begin
                if (!pend[k] && ($urandom % 3) == 0) begin
                    pend[k] = 1'b1;
                    pa[k]   = $urandom;
                    pwd[k]  = $urandom;
                    pwe[k]  = 1'($urandom);
                    pbe[k]  = 4'($urandom);
                end
                rq[k] = pend[k];
            end
            step(rq, 1'($urandom), (($urandom % 5) < 2), $urandom);
            for (int k = 0; k < NR; k++) if (e_gnt[k]) pend[k] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
